// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    // Total bits per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     rxclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted sampling, parity/frame tagging, break detect, receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          rxclk,
    input  logic                          reset,
    input  logic                          rx_enable,
    input  logic                          rx_in,
    input  logic                          rx_ready,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overrun,
    output logic                          rx_break,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned M     = OVERSAMPLE / 2;
    localparam int          CW    = $clog2(OVERSAMPLE);
    localparam int unsigned NBITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int          BW    = $clog2(NBITS + 1);
    localparam int          FW    = DATA_BITS + 2;

    localparam logic [CW-1:0] C_S1   = CW'(M - 1);
    localparam logic [CW-1:0] C_S2   = CW'(M);
    localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS);
    localparam logic [BW-1:0] B_LAST  = BW'(NBITS - 1);
    localparam parity_e       PAR     = parity_e'(PARITY[1:0]);

    rx_state_e state, state_n;

    logic [1:0]           sync;
    logic                 s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 v1, v2, maj;
    logic                 par, perr, ferr, allz;
    logic                 ferr_n, allz_n;
    logic                 decide, wrap;
    logic                 push, brk;
    logic                 fifo_full, fifo_empty, pop;
    logic [FW-1:0]        fifo_dout;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx_in};
    end
    assign s = sync[1];

    assign decide = (cnt == C_DEC);
    assign wrap   = (cnt == C_LAST);
    assign maj    = (v1 & v2) | (v1 & s) | (v2 & s);
    assign ferr_n = ferr | ~maj;
    assign allz_n = allz & ~maj;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rx_break <= 1'b0;
        end else begin
            state    <= state_n;
            rx_break <= brk;
        end
    end

    // bitn is the frame-wide bit index (0 = start), so state exits key off absolute positions.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        brk     = 1'b0;
        if (!rx_enable) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (!s) state_n = ST_START;
                ST_START: begin
                    if (decide && maj) state_n = ST_IDLE;
                    else if (wrap)     state_n = ST_DATA;
                end
                ST_DATA: begin
                    if (wrap && bitn == B_DLAST)
                        state_n = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: if (wrap) state_n = ST_STOP;
                ST_STOP: begin
                    if (decide && bitn == B_LAST) begin
                        if (allz_n) begin
                            brk     = 1'b1;
                            state_n = ST_BREAK_WAIT;
                        end else begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_BREAK_WAIT: if (s) state_n = ST_IDLE;
                default:       state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
            v1    <= 1'b1;
            v2    <= 1'b1;
            par   <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            allz  <= 1'b1;
        end else if (state == ST_IDLE || !rx_enable) begin
            cnt  <= '0;
            bitn <= '0;
            par  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            allz <= 1'b1;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)        bitn <= bitn + 1'b1;
            if (cnt == C_S1) v1 <= s;
            if (cnt == C_S2) v2 <= s;
            if (decide) begin
                case (state)
                    ST_DATA: begin
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                        par   <= par ^ maj;
                        allz  <= allz_n;
                    end
                    ST_PARITY: begin
                        perr <= ((par ^ maj) != (PAR == PAR_ODD));
                        allz <= allz_n;
                    end
                    ST_STOP: begin
                        ferr <= ferr_n;
                        allz <= allz_n;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop = !fifo_empty && rx_ready;

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .rxclk (rxclk),
        .reset (reset),
        .push  (push),
        .din   ({ferr_n, perr, shreg}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A simultaneous set outranks err_clr.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset)                          rx_overrun <= 1'b0;
        else if (push && fifo_full && !pop) rx_overrun <= 1'b1;
        else if (err_clr)                   rx_overrun <= 1'b0;
    end

    assign rx_data       = fifo_dout[DATA_BITS-1:0];
    assign rx_parity_err = fifo_dout[DATA_BITS];
    assign rx_frame_err  = fifo_dout[DATA_BITS+1];
    assign rx_valid      = !fifo_empty;
    assign rx_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance (u_a) and even-parity instance (u_b).
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       rxclk;
    logic       reset;
    logic       rx_enable;
    logic       err_clr;
    logic       rx_in_a, rx_ready_a;
    logic       rx_in_b, rx_ready_b;

    logic [7:0] data_a, data_b;
    logic       valid_a, ferr_a, perr_a, ovr_a, brk_a, busy_a;
    logic       valid_b, ferr_b, perr_b, ovr_b, brk_b, busy_b;
    logic [2:0] lvl_a, lvl_b;

    int errors = 0;
    int checks = 0;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_in_a),
        .rx_ready(rx_ready_a), .err_clr(err_clr), .rx_data(data_a), .rx_valid(valid_a),
        .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_overrun(ovr_a),
        .rx_break(brk_a), .rx_busy(busy_a), .fifo_level(lvl_a)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_in_b),
        .rx_ready(rx_ready_b), .err_clr(err_clr), .rx_data(data_b), .rx_valid(valid_b),
        .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_overrun(ovr_b),
        .rx_break(brk_b), .rx_busy(busy_b), .fifo_level(lvl_b)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    // Frame bit 0 is the start bit; bits go out LSB first, one bit per OS cycles.
    task automatic send_frame(input bit to_b, input logic [12:0] fr, input int nbits);
        for (int k = 0; k < nbits * OS; k++) begin
            if (to_b) rx_in_b = fr[k / OS];
            else      rx_in_a = fr[k / OS];
            @(negedge rxclk);
        end
        rx_in_a = 1'b1;
        rx_in_b = 1'b1;
    endtask

    task automatic pop_a();
        rx_ready_a = 1'b1;
        @(negedge rxclk);
        rx_ready_a = 1'b0;
    endtask

    task automatic pop_b();
        rx_ready_b = 1'b1;
        @(negedge rxclk);
        rx_ready_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rxclk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
        checks++; if (lvl_a !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
        checks++; if ({ferr_a, perr_a, ovr_a, brk_a, busy_a} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {ferr_a, perr_a, ovr_a, brk_a, busy_a});
        end
        reset = 1'b0;
        idle(3);
        checks++; if ({valid_b, busy_b, busy_a, valid_a} !== 4'b0) begin
            errors++; $display("FAIL post_reset_idle: got %b want 0000", {valid_b, busy_b, busy_a, valid_a});
        end
    endtask

    task automatic test_8n1();
        logic [12:0] fr;
        fr = {3'b000, 1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10 * OS; k++) begin
            rx_in_a = fr[k / OS];
            @(negedge rxclk);
            if (k + 1 == 156) begin
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL latency_early: valid got %b want 0", valid_a); end
            end
            if (k + 1 == 157) begin
                checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL latency_valid: valid got %b want 1", valid_a); end
                checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL data_a5: got %h want a5", data_a); end
                checks++; if ({ferr_a, perr_a} !== 2'b00) begin errors++; $display("FAIL tags_a5: got %b want 00", {ferr_a, perr_a}); end
            end
        end
        rx_in_a = 1'b1;
        idle(4);
        pop_a();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL pop_empty: valid got %b want 0", valid_a); end
        // Stop bit sampled low with nonzero data: frame error, not a break.
        send_frame(1'b0, {3'b000, 1'b0, 8'hF0, 1'b0}, 10);
        idle(20);
        checks++; if (data_a !== 8'hF0) begin errors++; $display("FAIL data_f0: got %h want f0", data_a); end
        checks++; if ({ferr_a, perr_a, brk_a} !== 3'b100) begin errors++; $display("FAIL ferr_f0: got %b want 100", {ferr_a, perr_a, brk_a}); end
        checks++; if (lvl_a !== 3'd1) begin errors++; $display("FAIL lvl_f0: got %0d want 1", lvl_a); end
        pop_a();
    endtask

    task automatic test_parity();
        // 0x3C has four ones: even parity bit is 0, so a 1 is wrong.
        send_frame(1'b1, {2'b00, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        idle(2);
        checks++; if (data_b !== 8'h3C) begin errors++; $display("FAIL par_data_3c: got %h want 3c", data_b); end
        checks++; if ({ferr_b, perr_b} !== 2'b01) begin errors++; $display("FAIL par_tags_3c: got %b want 01", {ferr_b, perr_b}); end
        pop_b();
        // 0x07 has three ones: even parity bit 1 is correct.
        send_frame(1'b1, {2'b00, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        idle(2);
        checks++; if (data_b !== 8'h07) begin errors++; $display("FAIL par_data_07: got %h want 07", data_b); end
        checks++; if ({ferr_b, perr_b} !== 2'b00) begin errors++; $display("FAIL par_tags_07: got %b want 00", {ferr_b, perr_b}); end
        pop_b();
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL par_drain: valid got %b want 0", valid_b); end
    endtask

    task automatic test_glitch();
        logic seen_busy;
        seen_busy = 1'b0;
        rx_in_a = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge rxclk);
            if (k == 5) rx_in_a = 1'b1;
            if (busy_a) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy_seen got %b want 1", seen_busy); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy_a); end
        idle(20);
        checks++; if (lvl_a !== 3'd0) begin errors++; $display("FAIL glitch_level: got %0d want 0", lvl_a); end
    endtask

    task automatic test_overrun();
        logic [7:0] w;
        for (int i = 1; i <= 5; i++) begin
            w = 8'(i);
            send_frame(1'b0, {3'b000, 1'b1, w, 1'b0}, 10);
            if (i == 4) begin
                checks++; if ({lvl_a, ovr_a} !== {3'd4, 1'b0}) begin
                    errors++; $display("FAIL ovr_four: level/ovr got %0d/%b want 4/0", lvl_a, ovr_a);
                end
            end
        end
        idle(2);
        checks++; if ({lvl_a, ovr_a} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL ovr_five: level/ovr got %0d/%b want 4/1", lvl_a, ovr_a);
        end
        idle(5);
        checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
        err_clr = 1'b1;
        @(negedge rxclk);
        err_clr = 1'b0;
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", ovr_a); end
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i);
            checks++; if ({valid_a, data_a} !== {1'b1, w}) begin
                errors++; $display("FAIL ovr_drain%0d: valid/data got %b/%h want 1/%h", i, valid_a, data_a, w);
            end
            pop_a();
        end
        checks++; if ({valid_a, lvl_a} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL ovr_empty: valid/level got %b/%0d want 0/0", valid_a, lvl_a);
        end
    endtask

    task automatic test_break();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 360; k++) begin
            rx_in_a = (k < 2 * 10 * OS) ? 1'b0 : 1'b1;
            @(negedge rxclk);
            if (brk_a) pulses++;
            if (k == 300) begin
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL break_wait_busy: got %b want 1", busy_a); end
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL break_pulses: got %0d want 1", pulses); end
        checks++; if ({busy_a, lvl_a, ferr_a} !== {1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL break_after: busy/level/ferr got %b/%0d/%b want 0/0/0", busy_a, lvl_a, ferr_a);
        end
    endtask

    task automatic test_enable_drop();
        logic [12:0] fr;
        send_frame(1'b0, {3'b000, 1'b1, 8'h11, 1'b0}, 10);
        idle(3);
        fr = {3'b000, 1'b1, 8'h5A, 1'b0};
        for (int k = 0; k < 10 * OS; k++) begin
            rx_in_a = fr[k / OS];
            if (k == 80) rx_enable = 1'b0;
            @(negedge rxclk);
            if (k == 81) begin
                checks++; if ({busy_a, lvl_a, data_a} !== {1'b0, 3'd1, 8'h11}) begin
                    errors++; $display("FAIL en_abort: busy/level/data got %b/%0d/%h want 0/1/11", busy_a, lvl_a, data_a);
                end
            end
        end
        rx_in_a = 1'b1;
        idle(5);
        checks++; if ({lvl_a, ferr_a, perr_a, ovr_a} !== {3'd1, 3'b000}) begin
            errors++; $display("FAIL en_quiet: level/flags got %0d/%b want 1/000", lvl_a, {ferr_a, perr_a, ovr_a});
        end
        rx_enable = 1'b1;
        idle(3);
        send_frame(1'b0, {3'b000, 1'b1, 8'h55, 1'b0}, 10);
        idle(2);
        checks++; if ({lvl_a, data_a} !== {3'd2, 8'h11}) begin
            errors++; $display("FAIL en_resume: level/data got %0d/%h want 2/11", lvl_a, data_a);
        end
        pop_a();
        checks++; if ({valid_a, data_a, ferr_a} !== {1'b1, 8'h55, 1'b0}) begin
            errors++; $display("FAIL en_55: valid/data/ferr got %b/%h/%b want 1/55/0", valid_a, data_a, ferr_a);
        end
        pop_a();
    endtask

    task automatic test_reset_mid();
        logic [12:0] fr;
        send_frame(1'b0, {3'b000, 1'b1, 8'h22, 1'b0}, 10);
        idle(2);
        fr = {3'b000, 1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 60; k++) begin
            rx_in_a = fr[k / OS];
            @(negedge rxclk);
        end
        reset = 1'b1;
        rx_in_a = 1'b1;
        @(negedge rxclk);
        checks++; if ({busy_a, valid_a, lvl_a, data_a, ovr_a} !== {1'b0, 1'b0, 3'd0, 8'h00, 1'b0}) begin
            errors++; $display("FAIL rst_mid: busy/valid/level/data/ovr got %b/%b/%0d/%h/%b want 0/0/0/00/0",
                               busy_a, valid_a, lvl_a, data_a, ovr_a);
        end
        idle(2);
        reset = 1'b0;
        idle(4);
        send_frame(1'b0, fr, 10);
        idle(2);
        checks++; if ({valid_a, data_a, ferr_a, perr_a, lvl_a} !== {1'b1, 8'h55, 2'b00, 3'd1}) begin
            errors++; $display("FAIL rst_recover: valid/data/tags/level got %b/%h/%b/%0d want 1/55/00/1",
                               valid_a, data_a, {ferr_a, perr_a}, lvl_a);
        end
    endtask

    initial begin
        reset      = 1'b1;
        rx_enable  = 1'b1;
        err_clr    = 1'b0;
        rx_in_a    = 1'b1;
        rx_in_b    = 1'b1;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        @(negedge rxclk);
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the successor to the fixed 8N1 receive path. Adds configurable word length, parity, stop bits and oversampling, 3-sample majority voting, break detection, per-word error tagging, and a receive FIFO with a valid/ready output. It sits between the synchronised serial input pin and the host-side register block, clocked by the oversampling clock rxclk.

## Interface
- DATA_BITS, 8: word length, legal values 5..9.
- OVERSAMPLE, 16: rxclk cycles per bit, even, at least 8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries, power of 2, at least 2.

- rxclk  in  1  oversampling clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- rx_enable  in  1  receiver enable.
- rx_in  in  1  asynchronous serial line, idle high.
- rx_ready  in  1  consumer accepts the head word.
- err_clr  in  1  one-cycle pulse; clears rx_overrun.
- rx_data  out  DATA_BITS  head-of-FIFO word, LSB first on the line.
- rx_valid  out  1  FIFO not empty.
- rx_frame_err  out  1  head word had a stop bit sampled 0; qualified by rx_valid.
- rx_parity_err  out  1  head word failed parity; qualified by rx_valid.
- rx_overrun  out  1  sticky: a word was dropped because the FIFO was full.
- rx_break  out  1  one-cycle pulse when a break is detected.
- rx_busy  out  1  a frame is in progress (state not IDLE).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- rx_in passes through a 2-flop synchroniser (both flops reset to 1); the output is `s`. The FSM sees only `s`.
- M = OVERSAMPLE/2. The bit counter `cnt` runs 0..OVERSAMPLE-1. Each bit value is the majority of `s` at cnt = M-1, M and M+1; the decision is taken at cnt = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: when rx_enable=1 and `s`=0, go to START with cnt=0.
  - START: if the majority is 1, go back to IDLE (glitch rejected). Otherwise continue and enter DATA at cnt wrap.
  - DATA: shift DATA_BITS decisions LSB first, then go to PARITY if PARITY≠0, else STOP.
  - PARITY: decide the parity bit, then go to STOP.
  - STOP: decide STOP_BITS bits. Any 0 sets the frame-error tag.
- Commit happens at the decision point of the last stop bit. The FSM returns to IDLE immediately, so hunting for the next start bit begins mid-stop-bit.
- Break: at commit, if every data, parity and stop decision was 0, pulse rx_break, push nothing, and enter BREAK_WAIT. Leave BREAK_WAIT for IDLE on the first cycle `s`=1.
- FIFO entry = {frame_err, parity_err, data}.
  - Pop when rx_valid && rx_ready.
  - A push is accepted if level < FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the word is dropped and rx_overrun is set.
- rx_overrun is cleared by err_clr. If a set and a clear happen in the same cycle, the set wins.
- rx_enable=0: the FSM aborts to IDLE within one cycle, with no push and no error. FIFO contents and popping are unaffected.
- Reset values: state IDLE, FIFO empty, rx_data 0, rx_valid 0, all error flags 0, rx_break 0, rx_busy 0, fifo_level 0.

## Timing
- Let d be the first rxclk edge at which `s`=0 in IDLE. Then let N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Commit occurs at cycle d + (N-1)·OVERSAMPLE + M + 1.
- rx_valid, rx_data and the tags are registered and appear on the cycle after commit.
- For 8N1 with OVERSAMPLE=16: commit at d+153, rx_valid at d+154.
- rx_break also asserts the cycle after commit.
- A pop takes effect at the edge. The next head word, or rx_valid=0, appears the following cycle.
- No combinational path from rx_ready to rx_valid.

## Structure
- Package uart_pkg holds:
  - the parity enum (NONE/EVEN/ODD);
  - the FSM state enum;
  - a function computing N from the parameters.
- Sub-module uart_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level, and support for a simultaneous push and pop when full.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → rx_valid at d+154 with rx_data=0xA5 and both error tags 0.
- PARITY=1, send 0x3C with a wrong parity bit → word 0x3C pushed with rx_parity_err=1 and rx_frame_err=0.
- rx_in low pulse of 5 cycles from idle → glitch rejected, no push, rx_busy drops back to 0 within 10 cycles.
- rx_ready=0, FIFO_DEPTH=4, send 5 words → fifo_level=4, 5th word dropped, rx_overrun=1 until err_clr, then 0.
- Line held low for 2 frame times → a single rx_break pulse, no push, no new frame until the line returns high.
- Reset asserted mid-DATA, and separately rx_enable dropped mid-frame → all outputs at reset values, or the FSM in IDLE with FIFO contents preserved; the next 0x55 frame is received correctly.
